// File: rtl/serial_mag_comparator_pkg.sv
// cmp_pkg: shared types for the bit-serial magnitude comparator.
//   state_t  - controller states (IDLE, SHIFT, DONE)
//   rel_t    - cascade relation triple {e, l, g}
//   REL_INIT - cascade seed before any bit has been compared (equal so far)
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic e;
    logic l;
    logic g;
  } rel_t;

  localparam rel_t REL_INIT = '{e: 1'b1, l: 1'b0, g: 1'b0};

endpackage

// File: rtl/serial_mag_comparator_cell.sv
// cmp_cell: one stage of a magnitude-comparator cascade, purely combinational.
// Ports:
//   a_bit_i - current bit of operand A
//   b_bit_i - current bit of operand B
//   rel_i   - relation accumulated over the more significant bits
//   rel_o   - relation including this bit
module cmp_cell
  import cmp_pkg::*;
(
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  rel_t rel_i,
  output rel_t rel_o
);

  // Once a more significant bit has decided (e=0), the l/g result is frozen;
  // only while still equal can this bit set one of them.
  always_comb begin
    rel_o   = rel_i;
    rel_o.e = rel_i.e & ~(a_bit_i ^ b_bit_i);
    rel_o.l = rel_i.l | (rel_i.e & ~a_bit_i & b_bit_i);
    rel_o.g = rel_i.g | (rel_i.e & a_bit_i & ~b_bit_i);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: compares two unsigned WIDTH-bit operands one bit per
// clock, MSB first, by feeding a single cmp_cell back on itself.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b sampled on accept)
//   out_valid / out_ready- result handshake
//   eq, lt, gt           - final relation of A against B (held until next result)
//   busy                 - high while comparing or holding a result
//   cycles               - number of bits compared to reach the current result
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       eq,
  output logic                       lt,
  output logic                       gt,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] cycles
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  rel_t             rel_q, rel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  rel_t             res_q, res_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  rel_t             cellOut;

  cmp_cell u_cell (
    .a_bit_i (sa_q[WIDTH-1]),
    .b_bit_i (sb_q[WIDTH-1]),
    .rel_i   (rel_q),
    .rel_o   (cellOut)
  );

  // Next-state logic. The published result (res/cyc) is a separate register
  // from the working cascade so it can stay visible while the next
  // comparison is running and after the result handshake completes.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          rel_d   = REL_INIT;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rel_d = cellOut;
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q == LAST_BIT) || (EARLY_EXIT && !cellOut.e)) begin
          res_d   = cellOut;
          cyc_d   = cnt_q + 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any comparison in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      rel_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign eq        = res_q.e;
  assign lt        = res_q.l;
  assign gt        = res_q.g;
  assign cycles    = cyc_q;

endmodule
